// File: rtl/mips_16_mem_pkg.sv
// Shared constants for the multi-channel MEM stage: writeback field layout,
// channel map, FSM encoding and the error read-data pattern.
package mips_16_mem_pkg;

    localparam int unsigned WB_W       = 5;
    localparam int unsigned WB_EN      = 4;
    localparam int unsigned WB_DEST_HI = 3;
    localparam int unsigned WB_DEST_LO = 1;
    localparam int unsigned WB_MUX     = 0;
    localparam int unsigned DEST_W     = WB_DEST_HI - WB_DEST_LO + 1;

    localparam int unsigned CH_RAM  = 0;
    localparam int unsigned CH_TRCD = 1;

    // Wide enough for any DATA_W in use; truncated at the point of use.
    localparam logic [63:0] ERR_DATA = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_mc.sv
// MEM stage between EX and WB: routes loads/stores to one of N_CH wait-stated
// channels with valid/ready on both sides, access timeout and hazard reporting.
module mem_stage_mc
    import mips_16_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CH_W    = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_alu,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic                   in_we,
    input  logic                   in_re,
    input  logic [CH_W-1:0]        in_ch,
    input  logic [WB_W-1:0]        in_wb,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_alu,
    output logic [DATA_W-1:0]      out_rdata,
    output logic [WB_W-1:0]        out_wb,
    output logic                   out_err,
    output logic [N_CH-1:0]        mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_we,
    input  logic [N_CH-1:0]        mem_ack,
    input  logic [N_CH*DATA_W-1:0] mem_rdata,
    output logic                   hz_dest_valid,
    output logic [DEST_W-1:0]      hz_dest
);

    localparam int unsigned TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_e              state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [WB_W-1:0]     wb_q, wb_d;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_alu_q, out_alu_d;
    logic [DATA_W-1:0]   out_rdata_q, out_rdata_d;
    logic [WB_W-1:0]     out_wb_q, out_wb_d;
    logic                out_err_q, out_err_d;
    logic [N_CH-1:0]     mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                hz_valid_q, hz_valid_d;
    logic [DEST_W-1:0]   hz_dest_q, hz_dest_d;

    logic                accept, is_mem, bad_ch, start_access;
    logic                ack_sel, tmo_hit, access_done;
    logic [DATA_W-1:0]   rdata_sel;
    logic [N_CH-1:0]     req_onehot;

    assign in_ready     = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign is_mem       = in_we || in_re;
    assign bad_ch       = 32'(in_ch) >= N_CH;
    assign start_access = accept && is_mem && !bad_ch;
    assign tmo_hit      = (TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LAST));
    assign access_done  = ack_sel || tmo_hit;

    // Channel decode: only the selected channel's ack and data are observed.
    always_comb begin
        ack_sel    = 1'b0;
        rdata_sel  = '0;
        req_onehot = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                ack_sel   = mem_ack[k];
                rdata_sel = mem_rdata[k*DATA_W +: DATA_W];
            end
            if (in_ch == CH_W'(k)) begin
                req_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_access) state_d = ACCESS;
            ACCESS:  if (access_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmo_d       = tmo_q;
        ch_d        = ch_q;
        alu_d       = alu_q;
        wb_d        = wb_q;
        out_valid_d = out_valid_q;
        out_alu_d   = out_alu_q;
        out_rdata_d = out_rdata_q;
        out_wb_d    = out_wb_q;
        out_err_d   = out_err_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        hz_valid_d  = hz_valid_q;
        hz_dest_d   = hz_dest_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_access) begin
                    tmo_d       = '0;
                    ch_d        = in_ch;
                    alu_d       = in_alu;
                    wb_d        = in_wb;
                    mem_req_d   = req_onehot;
                    mem_addr_d  = ADDR_W'(in_alu);
                    mem_wdata_d = in_wdata;
                    mem_we_d    = in_we;
                    hz_valid_d  = 1'b1;
                    hz_dest_d   = in_wb[WB_DEST_HI:WB_DEST_LO];
                end else if (accept) begin
                    // Non-memory op, or a memory op to a channel that does not exist.
                    out_valid_d = 1'b1;
                    out_alu_d   = in_alu;
                    out_wb_d    = in_wb;
                    out_rdata_d = (is_mem && bad_ch) ? DATA_W'(ERR_DATA) : '0;
                    out_err_d   = is_mem && bad_ch;
                end
            end
            ACCESS: begin
                if (access_done) begin
                    out_valid_d = 1'b1;
                    out_alu_d   = alu_q;
                    out_wb_d    = wb_q;
                    mem_req_d   = '0;
                    mem_we_d    = 1'b0;
                    hz_valid_d  = 1'b0;
                    hz_dest_d   = '0;
                    if (ack_sel) begin
                        out_rdata_d = mem_we_q ? '0 : rdata_sel;
                        out_err_d   = 1'b0;
                    end else begin
                        out_rdata_d = DATA_W'(ERR_DATA);
                        out_err_d   = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q       <= '0;
            ch_q        <= '0;
            alu_q       <= '0;
            wb_q        <= '0;
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            out_rdata_q <= '0;
            out_wb_q    <= '0;
            out_err_q   <= 1'b0;
            mem_req_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            hz_valid_q  <= 1'b0;
            hz_dest_q   <= '0;
        end else begin
            tmo_q       <= tmo_d;
            ch_q        <= ch_d;
            alu_q       <= alu_d;
            wb_q        <= wb_d;
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            out_rdata_q <= out_rdata_d;
            out_wb_q    <= out_wb_d;
            out_err_q   <= out_err_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            hz_valid_q  <= hz_valid_d;
            hz_dest_q   <= hz_dest_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_alu       = out_alu_q;
    assign out_rdata     = out_rdata_q;
    assign out_wb        = out_wb_q;
    assign out_err       = out_err_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_we        = mem_we_q;
    assign hz_dest_valid = hz_valid_q;
    assign hz_dest       = hz_dest_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: a per-cycle vector table for ALU/load/store
// flow, then hand sequences for wait states, timeout, reset and bad channel.
module tb_mem_stage_mc;
    import mips_16_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_alu;
    logic [15:0] in_wdata;
    logic        in_we;
    logic        in_re;
    logic [0:0]  in_ch;
    logic [4:0]  in_wb;
    logic        out_ready;
    logic [1:0]  mem_ack;
    logic [31:0] mem_rdata;

    logic        in_ready, out_valid, out_err, mem_we, hz_dest_valid;
    logic [15:0] out_alu, out_rdata, mem_wdata, mem_addr;
    logic [4:0]  out_wb;
    logic [1:0]  mem_req;
    logic [2:0]  hz_dest;

    logic        mem_ack1;
    logic [15:0] mem_rdata1;
    logic        in_ready1, out_valid1, out_err1, mem_we1, hz_dest_valid1;
    logic [15:0] out_alu1, out_rdata1, mem_wdata1, mem_addr1;
    logic [4:0]  out_wb1;
    logic [0:0]  mem_req1;
    logic [2:0]  hz_dest1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_mc u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu), .in_wdata(in_wdata),
        .in_we(in_we), .in_re(in_re), .in_ch(in_ch), .in_wb(in_wb),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_rdata(out_rdata), .out_wb(out_wb), .out_err(out_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hz_dest_valid(hz_dest_valid), .hz_dest(hz_dest)
    );

    mem_stage_mc #(.N_CH(1), .CH_W(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_alu(in_alu), .in_wdata(in_wdata),
        .in_we(in_we), .in_re(in_re), .in_ch(in_ch), .in_wb(in_wb),
        .out_valid(out_valid1), .out_ready(out_ready), .out_alu(out_alu1),
        .out_rdata(out_rdata1), .out_wb(out_wb1), .out_err(out_err1),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .mem_ack(mem_ack1), .mem_rdata(mem_rdata1),
        .hz_dest_valid(hz_dest_valid1), .hz_dest(hz_dest1)
    );

    typedef struct {
        logic        valid;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic        we;
        logic        re;
        logic        ch;
        logic [4:0]  wb;
        logic [1:0]  ack;
        logic [31:0] rdata;
        logic        ex_ready;
        logic        ex_ov;
        logic [15:0] ex_alu;
        logic [15:0] ex_rdata;
        logic        ex_err;
        logic [1:0]  ex_req;
        logic        ex_hz;
        logic [2:0]  ex_hzd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        // Cycle-by-cycle: three ALU ops, a zero-wait load, a store (we&re) with ack.
        tbl[0] = '{1'b1, 16'h0011, 16'h0, 1'b0, 1'b0, 1'b0, 5'b10010, 2'b00, 32'h0,
                   1'b1, 1'b1, 16'h0011, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 16'h0022, 16'h0, 1'b0, 1'b0, 1'b0, 5'b10100, 2'b00, 32'h0,
                   1'b1, 1'b1, 16'h0022, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0};
        tbl[2] = '{1'b1, 16'h0033, 16'h0, 1'b0, 1'b0, 1'b0, 5'b10110, 2'b00, 32'h0,
                   1'b1, 1'b1, 16'h0033, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0};
        tbl[3] = '{1'b1, 16'h0040, 16'h0, 1'b0, 1'b1, 1'b0, 5'b11011, 2'b00, 32'h0,
                   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b01, 1'b1, 3'd5};
        tbl[4] = '{1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b01, 32'h0000_BEEF,
                   1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 2'b00, 1'b0, 3'd0};
        tbl[5] = '{1'b1, 16'h0050, 16'hA5A5, 1'b1, 1'b1, 1'b0, 5'b00000, 2'b00, 32'h0,
                   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b01, 1'b1, 3'd0};
        tbl[6] = '{1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b01, 32'h0000_1111,
                   1'b0, 1'b1, 16'h0050, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0};
        tbl[7] = '{1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 32'h0,
                   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0};

        rst = 1'b1; in_valid = 1'b0; in_alu = '0; in_wdata = '0; in_we = 1'b0; in_re = 1'b0;
        in_ch = '0; in_wb = '0; out_ready = 1'b1; mem_ack = '0; mem_rdata = '0;
        mem_ack1 = 1'b0; mem_rdata1 = '0;
        tick();
        tick();
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_alu", 32'(out_alu), 0);
        chk("rst out_err", 32'(out_err), 0);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst hz_valid", 32'(hz_dest_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].valid; in_alu = tbl[i].alu; in_wdata = tbl[i].wdata;
            in_we = tbl[i].we; in_re = tbl[i].re; in_ch = tbl[i].ch; in_wb = tbl[i].wb;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ex_ready));
            tick();
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ex_ov));
            if (tbl[i].ex_ov) begin
                chk($sformatf("v%0d out_alu", i), 32'(out_alu), 32'(tbl[i].ex_alu));
                chk($sformatf("v%0d out_rdata", i), 32'(out_rdata), 32'(tbl[i].ex_rdata));
                chk($sformatf("v%0d out_err", i), 32'(out_err), 32'(tbl[i].ex_err));
            end
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].ex_req));
            chk($sformatf("v%0d hz_valid", i), 32'(hz_dest_valid), 32'(tbl[i].ex_hz));
            chk($sformatf("v%0d hz_dest", i), 32'(hz_dest), 32'(tbl[i].ex_hzd));
        end
        in_valid = 1'b0; in_we = 1'b0; in_re = 1'b0; mem_ack = '0;

        // Load on channel 1 with three wait states; channel-0 acks must be ignored.
        in_valid = 1'b1; in_alu = 16'h0060; in_re = 1'b1; in_ch = 1'(CH_TRCD); in_wb = 5'b10111;
        #1;
        chk("w in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_re = 1'b0;
        chk("w mem_addr", 32'(mem_addr), 32'h0060);
        chk("w mem_we", 32'(mem_we), 0);
        chk("w hz_dest", 32'(hz_dest), 3);
        cnt = 1;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("w%0d mem_req", w), 32'(mem_req), 32'b10);
            mem_ack = (w % 2 == 0) ? 2'b01 : 2'b00;
            mem_rdata = 32'h0000_DEAD;
            #1;
            chk($sformatf("w%0d in_ready", w), 32'(in_ready), 0);
            tick();
            chk($sformatf("w%0d out_valid", w), 32'(out_valid), 0);
            if (mem_req == 2'b10) cnt++;
        end
        chk("w req cycles", 32'(cnt), 4);
        mem_ack = 2'b11; mem_rdata = 32'h1234_DEAD;
        tick();
        mem_ack = '0;
        chk("w out_valid", 32'(out_valid), 1);
        chk("w out_rdata", 32'(out_rdata), 32'h1234);
        chk("w out_err", 32'(out_err), 0);
        chk("w out_alu", 32'(out_alu), 32'h0060);
        chk("w wb en", 32'(out_wb[WB_EN]), 1);
        chk("w wb mux", 32'(out_wb[WB_MUX]), 1);
        chk("w mem_req", 32'(mem_req), 0);

        // Load on channel 0 that is never acknowledged.
        in_valid = 1'b1; in_alu = 16'h0070; in_re = 1'b1; in_ch = 1'(CH_RAM); in_wb = 5'b10001;
        tick();
        in_valid = 1'b0; in_re = 1'b0;
        cnt = 0;
        while (mem_req == 2'b01 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to req cycles", 32'(cnt), 15);
        chk("to mem_req", 32'(mem_req), 0);
        chk("to out_valid", 32'(out_valid), 1);
        chk("to out_rdata", 32'(out_rdata), 32'hFFFF);
        chk("to out_err", 32'(out_err), 1);
        chk("to hz_valid", 32'(hz_dest_valid), 0);

        // Reset in the second wait cycle of a load; a late ack must produce nothing.
        in_valid = 1'b1; in_alu = 16'h0090; in_re = 1'b1; in_ch = 1'(CH_RAM); in_wb = 5'b10011;
        tick();
        in_valid = 1'b0; in_re = 1'b0;
        chk("rs wait1 req", 32'(mem_req), 32'b01);
        tick();
        chk("rs wait2 req", 32'(mem_req), 32'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs mem_req", 32'(mem_req), 0);
        chk("rs out_valid", 32'(out_valid), 0);
        chk("rs hz_valid", 32'(hz_dest_valid), 0);
        mem_ack = 2'b01; mem_rdata = 32'h0000_BEEF;
        tick();
        mem_ack = '0;
        chk("rs late out_valid", 32'(out_valid), 0);
        chk("rs late mem_req", 32'(mem_req), 0);
        tick();
        chk("rs late2 out_valid", 32'(out_valid), 0);

        // Single-channel build: store to channel 1 is a bad channel, then back-pressure.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_alu = 16'h00A0; in_wdata = 16'h5555; in_we = 1'b1; in_re = 1'b0;
        in_ch = 1'b1; in_wb = 5'b00010;
        #1;
        chk("bc in_ready", 32'(in_ready1), 1);
        tick();
        chk("bc mem_req", 32'(mem_req1), 0);
        chk("bc out_valid", 32'(out_valid1), 1);
        chk("bc out_err", 32'(out_err1), 1);
        chk("bc out_rdata", 32'(out_rdata1), 32'hFFFF);
        chk("bc out_alu", 32'(out_alu1), 32'h00A0);
        chk("bc hz_valid", 32'(hz_dest_valid1), 0);
        out_ready = 1'b0;
        in_alu = 16'h00B0; in_we = 1'b0; in_ch = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk($sformatf("bp%0d in_ready", s), 32'(in_ready1), 0);
            tick();
            chk($sformatf("bp%0d out_valid", s), 32'(out_valid1), 1);
            chk($sformatf("bp%0d out_alu", s), 32'(out_alu1), 32'h00A0);
            chk($sformatf("bp%0d out_err", s), 32'(out_err1), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp rel in_ready", 32'(in_ready1), 1);
        tick();
        in_valid = 1'b0;
        chk("bp rel out_valid", 32'(out_valid1), 1);
        chk("bp rel out_alu", 32'(out_alu1), 32'h00B0);
        chk("bp rel out_err", 32'(out_err1), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
